ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter.
//
// Sends one command byte to a PS/2 device using the host request-to-send
// sequence. The host first inhibits the bus by holding the clock low. It then
// pulls data low as the start bit and releases the clock. From then on it
// shifts out 8 data bits (LSB first), odd parity and a stop bit on the
// device-generated falling clock edges. Finally it checks the device ACK and
// waits for the bus to return to idle.
//
// Ports:
//   clk               system clock, the only clock
//   reset             asynchronous, active-high reset
//   send              single-cycle request to transmit cmd (ignored while busy)
//   cmd[7:0]          command byte, latched when send is accepted
//   ps2_clk_in        raw PS2_CLK pad level (asynchronous)
//   ps2_dat_in        raw PS2_DAT pad level (asynchronous)
//   ps2_clk_drive_low 1 = pull PS2_CLK low, 0 = release (open-drain)
//   ps2_dat_drive_low 1 = pull PS2_DAT low, 0 = release (open-drain)
//   busy              high from accepted send until done/error
//   done              one-cycle pulse: byte sent and ACK received
//   error             one-cycle pulse: missing ACK or timeout
//
// All outputs are registered, so the async reset clears them immediately.

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // One counter serves both the inhibit interval and the transfer timeout;
  // the two phases never overlap.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                   INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StData,
    StAckWait,
    StLineIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            parity_q, parity_d;
  logic            clk_drv_q, clk_drv_d;
  logic            dat_drv_q, dat_drv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  // Two-flop synchronisers plus one history flop for clock edge detection.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  logic clk_fall;
  logic timeout_hit;

  assign clk_fall    = clk_prev_q & ~clk_sync_q;
  assign timeout_hit = (cnt_q == TimeoutLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    parity_d  = parity_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        busy_d    = 1'b0;
        if (send) begin
          cmd_d     = cmd;
          parity_d  = ~^cmd;
          clk_drv_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = StInhibit;
        end
      end

      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          // Start bit: data pulled low while the clock is still held.
          dat_drv_d = 1'b1;
          cnt_d     = '0;
          state_d   = StStart;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStart: begin
        // Release the clock; the device now generates it. Timeout starts here.
        clk_drv_d = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = StData;
      end

      StData, StAckWait, StLineIdle: begin
        cnt_d = cnt_q + CntW'(1);
        if (timeout_hit) begin
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b0;
          busy_d    = 1'b0;
          error_d   = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end else if (state_q == StData) begin
          if (clk_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              // Drive low for a 0 bit, release for a 1 bit.
              dat_drv_d = ~cmd_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              dat_drv_d = ~parity_q;
            end else begin
              // Stop bit: release data and let the device ACK on edge 11.
              dat_drv_d = 1'b0;
              state_d   = StAckWait;
            end
          end
        end else if (state_q == StAckWait) begin
          if (clk_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (!dat_sync_q) begin
              state_d = StLineIdle;
            end else begin
              busy_d    = 1'b0;
              error_d   = 1'b1;
              cnt_d     = '0;
              bit_cnt_d = '0;
              state_d   = StIdle;
            end
          end
        end else begin
          if (clk_sync_q && dat_sync_q) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cnt_d     = '0;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end
        end
      end

      default: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      parity_q   <= 1'b0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      // Synchronisers reset to the idle (released) bus level.
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      parity_q   <= parity_d;
      clk_drv_q  <= clk_drv_d;
      dat_drv_q  <= dat_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign ps2_clk_drive_low = clk_drv_q;
  assign ps2_dat_drive_low = dat_drv_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: an open-drain bus with a simple PS/2 device model
// that clocks the frame, samples the data line at the end of each high phase
// and optionally ACKs on edge 11. Expected frames are built from the byte.
module tb_ps2_host_tx;

  localparam int unsigned Inh  = 60;
  localparam int unsigned Tmo  = 2000;
  localparam int          Half = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] cmd;
  logic       dev_clk;
  logic       dev_dat;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_drive_low;
  logic       ps2_dat_drive_low;
  logic       busy;
  logic       done;
  logic       error;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;

  // Wired-AND open-drain bus.
  assign ps2_clk_in = dev_clk & ~ps2_clk_drive_low;
  assign ps2_dat_in = dev_dat & ~ps2_dat_drive_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .send              (send),
    .cmd               (cmd),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_dat_in        (ps2_dat_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling clk edge and account for any output pulse.
  task automatic tick();
    @(negedge clk);
    if (done === 1'b1 || error === 1'b1) begin
      if (done === 1'b1) n_done++;
      if (error === 1'b1) n_err++;
      chk("busy_low_on_pulse", {31'd0, busy}, 32'd0);
      chk("done_error_exclusive", {31'd0, done & error}, 32'd0);
    end
  endtask

  // Line levels of the 11-bit frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] c);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(c[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = c[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_send(input logic [7:0] c);
    send = 1'b1;
    cmd  = c;
    tick();
    send = 1'b0;
    cmd  = 8'($urandom);
    chk("busy_after_send", {31'd0, busy}, 32'd1);
  endtask

  // Leaves the sample point on the first cycle after the clock is released.
  task automatic check_inhibit();
    int n = 0;
    while (ps2_clk_drive_low === 1'b1 && ps2_dat_drive_low === 1'b0 && n < int'(Inh) + 20) begin
      n++;
      tick();
    end
    chk("inhibit_len", n, Inh);
    chk("start_clk_low", {31'd0, ps2_clk_drive_low}, 32'd1);
    chk("start_dat_low", {31'd0, ps2_dat_drive_low}, 32'd1);
    tick();
    chk("release_clk", {31'd0, ps2_clk_drive_low}, 32'd0);
    chk("release_dat", {31'd0, ps2_dat_drive_low}, 32'd1);
  endtask

  task automatic device_clock(input logic [10:0] exp, input int edges, input bit ack);
    for (int k = 1; k <= edges; k++) begin
      repeat (Half) tick();
      chk($sformatf("frame_bit%0d", k - 1), {31'd0, ps2_dat_in}, {31'd0, exp[k-1]});
      dev_clk = 1'b0;
      if (k == 11 && ack) dev_dat = 1'b0;
      repeat (Half) tick();
      dev_clk = 1'b1;
    end
  endtask

  task automatic run_xfer(input logic [7:0] c, input bit ack);
    int d0 = n_done;
    int e0 = n_err;
    start_send(c);
    check_inhibit();
    device_clock(frame_of(c), 11, ack);
    repeat (Half) tick();
    dev_dat = 1'b1;
    repeat (20) tick();
    chk($sformatf("done_count_%02h", c), n_done - d0, ack ? 1 : 0);
    chk($sformatf("error_count_%02h", c), n_err - e0, ack ? 0 : 1);
    chk("end_clk_drive", {31'd0, ps2_clk_drive_low}, 32'd0);
    chk("end_dat_drive", {31'd0, ps2_dat_drive_low}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    int e0;
    int n;

    reset   = 1'b1;
    send    = 1'b0;
    cmd     = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk_drive", {31'd0, ps2_clk_drive_low}, 32'd0);
    chk("rst_dat_drive", {31'd0, ps2_dat_drive_low}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {30'd0, done, error}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed bytes, including the parity corner cases.
    run_xfer(8'hED, 1'b1);
    run_xfer(8'h00, 1'b1);
    run_xfer(8'hFF, 1'b1);
    run_xfer(8'h01, 1'b1);
    for (int i = 0; i < 4; i++) run_xfer(8'($urandom), 1'b1);

    // Device leaves data high on edge 11.
    run_xfer(8'($urandom), 1'b0);

    // Device never clocks: timeout measured from clock release.
    d0 = n_done;
    e0 = n_err;
    start_send(8'h3C);
    check_inhibit();
    n = 0;
    while (error !== 1'b1 && n < int'(Tmo) + 50) begin
      n++;
      if (n == 100) begin
        send = 1'b1;
        cmd  = 8'h55;
      end
      if (n == 101) send = 1'b0;
      tick();
    end
    chk("timeout_len", n, Tmo);
    chk("timeout_clk_drive", {31'd0, ps2_clk_drive_low}, 32'd0);
    chk("timeout_dat_drive", {31'd0, ps2_dat_drive_low}, 32'd0);
    repeat (30) tick();
    chk("timeout_error_count", n_err - e0, 1);
    chk("timeout_done_count", n_done - d0, 0);
    chk("after_timeout_busy", {31'd0, busy}, 32'd0);
    chk("after_timeout_clk", {31'd0, ps2_clk_drive_low}, 32'd0);

    // Reset mid-DATA after edge 4; cmd bit 3 is 0 so data is being driven low.
    start_send(8'hA5);
    check_inhibit();
    device_clock(frame_of(8'hA5), 4, 1'b0);
    chk("pre_reset_dat", {31'd0, ps2_dat_drive_low}, 32'd1);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    d0 = n_done;
    e0 = n_err;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_clk", {31'd0, ps2_clk_drive_low}, 32'd0);
    chk("async_rst_dat", {31'd0, ps2_dat_drive_low}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_pulses", {30'd0, done, error}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_error", n_err - e0, 0);
    run_xfer(8'hF4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
